// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BE_W            = 4;
  localparam int unsigned MAX_WAIT_CYCLES = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ram_bank.sv
// Byte-enabled word array: one registered read port, one write port, no reset.
module ram_bank
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory slave with a programmable number of wait states and out-of-range error reporting.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Mem_Req,
  input  logic        Mem_Write,
  input  logic [31:0] Mem_Addr,
  input  logic [31:0] Mem_W_Data,
  input  logic [3:0]  MW,
  output logic [31:0] Mem_R_Data,
  output logic        Mem_Ready,
  output logic        Mem_Err
);

  if (WAIT_CYCLES > MAX_WAIT_CYCLES) begin : gen_wait_range
    $error("mem_responder: WAIT_CYCLES out of range");
  end

  localparam logic [3:0] WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q;
  logic [31:2]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   mw_q;
  logic              accept;
  logic              oor;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_raddr;
  logic [WORD_W-1:0] ram_rdata;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^Mem_Addr[1:0];
  assign accept          = (state_q == IDLE) && Mem_Req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= Mem_Write;
        addr_q  <= Mem_Addr[31:2];
        wdata_q <= Mem_W_Data;
        mw_q    <= MW;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Mem_Req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WaitLoad;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign oor = |addr_q[31:ADDR_W+2];

  // Read address follows the incoming request on the accept edge so that read data is
  // already valid in RESP even with zero wait states.
  assign ram_raddr = accept ? Mem_Addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
  assign ram_we    = (state_q == RESP) && write_q && !oor && !rst;

  ram_bank #(
    .ADDR_W(ADDR_W)
  ) u_ram_bank (
    .clk  (clk),
    .we   (ram_we),
    .be   (mw_q),
    .waddr(addr_q[ADDR_W+1:2]),
    .wdata(wdata_q),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign Mem_Ready  = (state_q == RESP);
  assign Mem_Err    = Mem_Ready && oor;
  assign Mem_R_Data = (Mem_Ready && !write_q && !oor) ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: three responders (0, 1 and 3 wait states) share one request bus.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst1, rst0, rst3;
  logic        req, wr;
  logic [31:0] addr, wdata;
  logic [3:0]  mw;

  logic [31:0] d1_data, d0_data, d3_data;
  logic        d1_ready, d0_ready, d3_ready;
  logic        d1_err, d0_err, d3_err;

  int          sel;
  logic [31:0] o_data;
  logic        o_ready, o_err;
  logic        seen;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(6), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst1), .Mem_Req(req), .Mem_Write(wr), .Mem_Addr(addr),
    .Mem_W_Data(wdata), .MW(mw), .Mem_R_Data(d1_data), .Mem_Ready(d1_ready), .Mem_Err(d1_err)
  );

  mem_responder #(.ADDR_W(6), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst0), .Mem_Req(req), .Mem_Write(wr), .Mem_Addr(addr),
    .Mem_W_Data(wdata), .MW(mw), .Mem_R_Data(d0_data), .Mem_Ready(d0_ready), .Mem_Err(d0_err)
  );

  mem_responder #(.ADDR_W(6), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst3), .Mem_Req(req), .Mem_Write(wr), .Mem_Addr(addr),
    .Mem_W_Data(wdata), .MW(mw), .Mem_R_Data(d3_data), .Mem_Ready(d3_ready), .Mem_Err(d3_err)
  );

  always_comb begin
    o_data  = d1_data;
    o_ready = d1_ready;
    o_err   = d1_err;
    if (sel == 0) begin
      o_data  = d0_data;
      o_ready = d0_ready;
      o_err   = d0_err;
    end else if (sel == 3) begin
      o_data  = d3_data;
      o_ready = d3_ready;
      o_err   = d3_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold every responder in reset, then release only the selected one.
  task automatic reset_dut(input int s);
    @(negedge clk);
    req  = 1'b0;
    rst1 = 1'b1;
    rst0 = 1'b1;
    rst3 = 1'b1;
    repeat (2) @(negedge clk);
    sel  = s;
    rst1 = (s != 1);
    rst0 = (s != 0);
    rst3 = (s != 3);
    chk($sformatf("rst%0d.ready", s), {31'b0, o_ready}, 32'h0);
    chk($sformatf("rst%0d.err", s), {31'b0, o_err}, 32'h0);
    chk($sformatf("rst%0d.data", s), o_data, 32'h0);
  endtask

  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, input int exp_lat,
                        input logic exp_err, input logic [31:0] exp_data, input logic glitch);
    int lat;
    @(negedge clk);
    req   = 1'b1;
    wr    = w;
    addr  = a;
    wdata = d;
    mw    = m;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    if (glitch) begin
      addr  = a + 32'h4;
      wdata = ~d;
    end
    while (!o_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".err"}, {31'b0, o_err}, {31'b0, exp_err});
    chk({tag, ".data"}, o_data, exp_data);
    @(negedge clk);
    chk({tag, ".pulse"}, {31'b0, o_ready}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; mw = '0;
    rst1 = 1'b1; rst0 = 1'b1; rst3 = 1'b1; sel = 1;

    // One wait state.
    reset_dut(1);
    access("wr08", 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 2, 1'b0, 32'h0, 1'b0);
    access("rd08", 1'b0, 32'h08, 32'h0, 4'h0, 2, 1'b0, 32'hDEADBEEF, 1'b0);
    access("wr10", 1'b1, 32'h10, 32'h11223344, 4'hF, 2, 1'b0, 32'h0, 1'b0);
    access("wr10be", 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 2, 1'b0, 32'h0, 1'b0);
    access("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 2, 1'b0, 32'h11BB33DD, 1'b0);
    access("wr00", 1'b1, 32'h00, 32'h12345678, 4'hF, 2, 1'b0, 32'h0, 1'b0);
    access("wr100", 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 2, 1'b1, 32'h0, 1'b0);
    access("rd100", 1'b0, 32'h100, 32'h0, 4'hF, 2, 1'b1, 32'h0, 1'b0);
    access("rd00", 1'b0, 32'h00, 32'h0, 4'h0, 2, 1'b0, 32'h12345678, 1'b0);
    access("wr08mw0", 1'b1, 32'h08, 32'h0, 4'h0, 2, 1'b0, 32'h0, 1'b0);
    access("rd08b", 1'b0, 32'h08, 32'h0, 4'hF, 2, 1'b0, 32'hDEADBEEF, 1'b0);
    access("wr18", 1'b1, 32'h18, 32'h55555555, 4'hF, 2, 1'b0, 32'h0, 1'b0);
    access("wr14g", 1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 2, 1'b0, 32'h0, 1'b1);
    access("rd14", 1'b0, 32'h14, 32'h0, 4'h0, 2, 1'b0, 32'hCAFEF00D, 1'b0);
    access("rd18", 1'b0, 32'h18, 32'h0, 4'h0, 2, 1'b0, 32'h55555555, 1'b0);

    // Zero wait states, request held for six sampling edges.
    reset_dut(0);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'hA5A50000; mw = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("b2b.c%0d", k), {31'b0, o_ready}, 32'(k % 2));
    end
    req = 1'b0;
    @(negedge clk);
    chk("b2b.c7", {31'b0, o_ready}, 32'h0);
    access("rd20", 1'b0, 32'h20, 32'h0, 4'h0, 1, 1'b0, 32'hA5A50000, 1'b0);

    // Three wait states; abort by reset in the second WAIT cycle.
    reset_dut(3);
    access("wr04", 1'b1, 32'h04, 32'h01020304, 4'hF, 4, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h04; wdata = 32'hFFFFFFFF; mw = 4'hF;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      if (o_ready) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort.noready", {31'b0, seen}, 32'h0);
    access("rd04", 1'b0, 32'h04, 32'h0, 4'h0, 4, 1'b0, 32'h01020304, 1'b0);

    // Reset and request on the same edge: reset wins.
    @(negedge clk);
    rst3 = 1'b1; req = 1'b1; wr = 1'b1; addr = 32'h04; wdata = 32'h0; mw = 4'hF;
    @(negedge clk);
    rst3 = 1'b0; req = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      if (o_ready) seen = 1'b1;
      @(negedge clk);
    end
    chk("prio.noready", {31'b0, seen}, 32'h0);
    access("rd04b", 1'b0, 32'h04, 32'h0, 4'h0, 4, 1'b0, 32'h01020304, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
